// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the segment-pipelined adder/subtractor.
// Optional feature macro: SATURATE_EN (clamp out_sum on signed overflow).
package pipelined_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Per-stage control payload travelling with the operand/sum vectors.
    // carry: carry into the next segment (carry-out of the last one at the end)
    // a_msb/b_msb: sign bits of A and effective B, kept for the overflow check
    typedef struct packed {
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_ctrl_t;

endpackage

// File: rtl/pipelined_addsub_segment.sv
// SEG-bit combinational slice adder: {cout, sum} = a + b + cin.
module pipelined_addsub_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// Segment-pipelined two's-complement adder/subtractor with valid/ready streaming.
// Stage k resolves bits [k*SEG +: SEG]; full operands ride along so upper slices
// are naturally skewed forward and finished lower slices naturally delayed.
// Optional feature macro: SATURATE_EN (clamp result on signed overflow).
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_c,
    input  logic         in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_c,
    output logic         out_ovf,
    output logic         out_zero
);

    localparam int STAGES = N / SEG;
    localparam int LAST   = STAGES - 1;

    // Stage registers
    logic [STAGES-1:0] vld_q, vld_d;
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      a_d   [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic [N-1:0]      b_d   [STAGES];
    logic [N-1:0]      sum_q [STAGES];
    logic [N-1:0]      sum_d [STAGES];
    stage_ctrl_t       ctrl_q[STAGES];
    stage_ctrl_t       ctrl_d[STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // Per-stage sources (input port for stage 0, previous stage register otherwise)
    logic [N-1:0]      src_a   [STAGES];
    logic [N-1:0]      src_b   [STAGES];
    logic [N-1:0]      src_sum [STAGES];
    stage_ctrl_t       src_ctrl[STAGES];
    logic [STAGES-1:0] src_vld;

    // Segment adder hookup
    logic [SEG-1:0]    seg_a  [STAGES];
    logic [SEG-1:0]    seg_b  [STAGES];
    logic [SEG-1:0]    seg_sum[STAGES];
    logic [STAGES-1:0] seg_cin;
    logic [STAGES-1:0] seg_cout;

    // Stage load enables
    logic [STAGES-1:0] ld;

`ifdef SATURATE_EN
    function automatic logic [N-1:0] saturate(input logic [N-1:0] s, input logic ovf,
                                              input logic a_msb);
        logic [N-1:0] r;
        r = s;
        if (ovf) begin
            r = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
        return r;
    endfunction
`endif

    // Stage k advances unless it and every stage after it are full and the sink stalls
    always_comb begin
        logic [STAGES-1:0] mask;
        ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            mask  = {STAGES{1'b1}} << k;
            ld[k] = out_ready || ((vld_q & mask) != mask);
        end
    end

    // Select each stage's source and slice out the segment it resolves
    always_comb begin
        src_a[0]          = in_a;
        src_b[0]          = (in_op == OP_SUB) ? ~in_b : in_b;
        src_sum[0]        = '0;
        src_ctrl[0].carry = (in_op == OP_SUB) ? ~in_c : in_c;
        src_ctrl[0].a_msb = in_a[N-1];
        src_ctrl[0].b_msb = src_b[0][N-1];
        src_vld[0]        = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]    = a_q[k-1];
            src_b[k]    = b_q[k-1];
            src_sum[k]  = sum_q[k-1];
            src_ctrl[k] = ctrl_q[k-1];
            src_vld[k]  = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_a[k]   = src_a[k][k*SEG +: SEG];
            seg_b[k]   = src_b[k][k*SEG +: SEG];
            seg_cin[k] = src_ctrl[k].carry;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        pipelined_addsub_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (seg_a[g]),
            .b    (seg_b[g]),
            .cin  (seg_cin[g]),
            .sum  (seg_sum[g]),
            .cout (seg_cout[g])
        );
    end

    // Next state: move beats forward, merge the new slice, finish flags in the last stage
    always_comb begin
        logic [N-1:0] raw_sum;
        logic [N-1:0] fin_sum;
        logic         ovf_raw;
        raw_sum = '0;
        fin_sum = '0;
        ovf_raw = 1'b0;
        vld_d   = vld_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = ld[k] ? src_vld[k] : vld_q[k];
            if (ld[k] && src_vld[k]) begin
                a_d[k]                 = src_a[k];
                b_d[k]                 = src_b[k];
                sum_d[k]               = src_sum[k];
                sum_d[k][k*SEG +: SEG] = seg_sum[k];
                ctrl_d[k]              = src_ctrl[k];
                ctrl_d[k].carry        = seg_cout[k];
            end
        end
        if (ld[LAST] && src_vld[LAST]) begin
            raw_sum = sum_d[LAST];
            ovf_raw = (src_ctrl[LAST].a_msb == src_ctrl[LAST].b_msb) &&
                      (raw_sum[N-1] != src_ctrl[LAST].a_msb);
`ifdef SATURATE_EN
            fin_sum = saturate(raw_sum, ovf_raw, src_ctrl[LAST].a_msb);
`else
            fin_sum = raw_sum;
`endif
            sum_d[LAST] = fin_sum;
            ovf_d       = ovf_raw;
            zero_d      = (fin_sum == '0);
        end
    end

    // Pipeline state; reset clears every stage so in-flight beats are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                sum_q[k]  <= '0;
                ctrl_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_c     = ctrl_q[LAST].carry;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule
